// File: rtl/edge_detect.sv
// Registered per-bit rising/falling edge detector with one-cycle output pulses.
// Optional EDGE_DETECT_SYNC_EN adds a 2-flop input synchronizer (latency +2 cycles).
module edge_detect #(
    parameter int   WIDTH       = 1,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] rising_edge,
    output logic [WIDTH-1:0] falling_edge
);

    logic [WIDTH-1:0] sample;
    logic [WIDTH-1:0] in_d,   in_q;
    logic [WIDTH-1:0] rise_d, rise_q;
    logic [WIDTH-1:0] fall_d, fall_q;

`ifdef EDGE_DETECT_SYNC_EN
    logic [WIDTH-1:0] sync1_d, sync1_q;
    logic [WIDTH-1:0] sync2_d, sync2_q;

    always_comb begin
        sync1_d = in;
        sync2_d = sync1_q;
    end

    // Synchronizer resets to the idle level so reset release creates no false edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= {WIDTH{RESET_LEVEL}};
            sync2_q <= {WIDTH{RESET_LEVEL}};
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign sample = sync2_q;
`else
    assign sample = in;
`endif

    always_comb begin
        in_d   = sample;
        rise_d = sample & ~in_q;
        fall_d = ~sample & in_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_q   <= {WIDTH{RESET_LEVEL}};
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            in_q   <= in_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rising_edge  = rise_q;
    assign falling_edge = fall_q;

endmodule

// File: tb/tb_edge_detect.sv
// Bench for edge_detect (WIDTH=4, RESET_LEVEL=0, default build without input synchronizer).
module tb_edge_detect;

    localparam int W = 4;

    logic         clk;
    logic         reset_n;
    logic [W-1:0] in;
    logic [W-1:0] rising_edge;
    logic [W-1:0] falling_edge;

    logic [2*W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;
    int vec_idx  = 0;

    edge_detect #(.WIDTH(W), .RESET_LEVEL(1'b0)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in           (in),
        .rising_edge  (rising_edge),
        .falling_edge (falling_edge)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [2*W-1:0] act,
                                  input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got rise=%b fall=%b, expected rise=%b fall=%b",
                     name, act[2*W-1:W], act[W-1:0], exp[2*W-1:W], exp[W-1:0]);
        end
    endfunction

    // driver: apply a vector on the negedge and queue the output expected after the next posedge
    task automatic drive(input logic rn, input logic [W-1:0] v,
                         input logic [W-1:0] er, input logic [W-1:0] ef);
        @(negedge clk);
        reset_n = rn;
        in      = v;
        exp_q.push_back({er, ef});
    endtask

    // monitor / scoreboard: outputs are present every cycle, compared just after each posedge
    initial begin
        logic [2*W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check($sformatf("vec%0d", vec_idx), {rising_edge, falling_edge}, e);
                vec_idx++;
            end
        end
    end

    // watchdog
    initial begin
        #100000;
        failures++;
        $display("FAIL timeout: simulation did not complete, got still running, expected done");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int wait_cycles;
        reset_n = 1'b0;
        in      = '0;
        #2;
        check("reset_at_start", {rising_edge, falling_edge}, '0);

        // reset held while in toggles: outputs stay 0
        drive(1'b0, 4'b1111, 4'b0000, 4'b0000);
        drive(1'b0, 4'b0000, 4'b0000, 4'b0000);
        drive(1'b0, 4'b1010, 4'b0000, 4'b0000);
        drive(1'b0, 4'b0011, 4'b0000, 4'b0000);

        // release with in=0011: first sample compared against RESET_LEVEL=0
        drive(1'b1, 4'b0011, 4'b0011, 4'b0000);
        drive(1'b1, 4'b0011, 4'b0000, 4'b0000);
        drive(1'b1, 4'b0011, 4'b0000, 4'b0000);

        // mixed per-bit edges
        drive(1'b1, 4'b0101, 4'b0100, 4'b0010);
        drive(1'b1, 4'b1010, 4'b1010, 4'b0101);
        // bit3 held high for 10 cycles: single rise above, then quiet
        for (int i = 0; i < 9; i++) drive(1'b1, 4'b1010, 4'b0000, 4'b0000);
        drive(1'b1, 4'b0000, 4'b0000, 4'b1010);
        drive(1'b1, 4'b0000, 4'b0000, 4'b0000);

        // pulse widths 1..10 on bit0: rise at start, fall after width cycles
        for (int w = 1; w <= 10; w++) begin
            drive(1'b1, 4'b0001, 4'b0001, 4'b0000);
            for (int k = 1; k < w; k++) drive(1'b1, 4'b0001, 4'b0000, 4'b0000);
            drive(1'b1, 4'b0000, 4'b0000, 4'b0001);
            drive(1'b1, 4'b0000, 4'b0000, 4'b0000);
        end

        // bit independence
        drive(1'b1, 4'b1111, 4'b1111, 4'b0000);
        drive(1'b1, 4'b1110, 4'b0000, 4'b0001);
        drive(1'b1, 4'b0001, 4'b0001, 4'b1110);

        // async reset mid-pulse: outputs clear without a clock edge
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_reset_clear", {rising_edge, falling_edge}, '0);
        drive(1'b0, 4'b0001, 4'b0000, 4'b0000);
        // release with in still high: in_q was reset to 0, so one rising pulse
        drive(1'b1, 4'b0001, 4'b0001, 4'b0000);
        drive(1'b1, 4'b0001, 4'b0000, 4'b0000);
        drive(1'b1, 4'b0001, 4'b0000, 4'b0000);

        wait_cycles = 0;
        while (exp_q.size() != 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
